sr_flag_arbiter: RTL and testbench
==================================

Name: sr_flag_arbiter

Overview:
- Shared bank of NFLAGS set/reset flag bits, one SR flip-flop per bit, written by NREQ independent requesters.
- Each requester issues an S/R command for one flag index over a valid/ready handshake.
- A round-robin arbiter accepts at most one command per cycle and applies it to the bank.
- An illegal S=R=1 command leaves the flag unchanged and records a per-requester sticky error.

Parameters:
- NREQ, 4, number of requesters (2..16).
- NFLAGS, 8, number of flag bits in the bank (2..64).
- IDXW, 3, width of a flag index; must satisfy 2**IDXW >= NFLAGS.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i presents a command.
- req_ready  output  NREQ  bit i: command i accepted this cycle (combinational).
- req_s  input  NREQ  bit i: set request of requester i.
- req_r  input  NREQ  bit i: reset request of requester i.
- req_idx  input  NREQ*IDXW  slice [i*IDXW +: IDXW]: target flag of requester i.
- flags  output  NFLAGS  registered flag bank state.
- upd_valid  output  1  registered pulse: a command was applied last cycle.
- upd_req  output  IDXW  registered; holds the requester ID of the applied command in its low bits.
- upd_idx  output  IDXW  registered flag index of the applied command.
- err  output  NREQ  sticky illegal-command flags, one per requester.
- err_clr  input  NREQ  bit i clears err[i].

Behaviour:
- Reset is sampled on the clk rising edge. When reset=1:
  - flags=0, err=0, upd_valid=0, upd_req=0, upd_idx=0.
  - The round-robin pointer resets to 0, so requester 0 has highest priority.
  - req_ready is forced to all-zero while reset=1, even combinationally.
- Arbitration is combinational from req_valid and the pointer ptr.
  - Search order is ptr, ptr+1, ... NREQ-1, 0, ... ptr-1.
  - The first requester with valid=1 is granted.
  - req_ready is one-hot on the granted bit, or all-zero if no requester is valid.
- Transfer occurs when req_valid[i] & req_ready[i]. At that clock edge:
  - ptr becomes (i+1) mod NREQ.
  - If no transfer occurs, ptr holds.
- Command decode at transfer, applied at the same edge; the result is visible on flags the next cycle (latency 1):
  - S=1, R=0: flags[idx] becomes 1.
  - S=0, R=1: flags[idx] becomes 0.
  - S=0, R=0: no change (legal no-op; still consumes the grant).
  - S=1, R=1: illegal; flags unchanged and err[i] is set.
- Index out of range (idx >= NFLAGS): treated as illegal. flags are unchanged and err[i] is set.
- upd_valid=1 for exactly one cycle after every transfer, including no-ops and illegal commands.
  - upd_req and upd_idx hold that transfer's values, and are held otherwise.
- err[i]: if set and clear occur in the same cycle, set wins. err_clr[i] with err[i]=0 has no effect.
- Requester rules:
  - Once valid is asserted, req_s, req_r and req_idx must be held stable until ready.
  - A requester may drop valid without transfer; this is legal and has no side effects.
  - Back-to-back commands from the same requester are allowed, but rotation means it gets at most 1 of every k cycles when k requesters are active.
- Same flag targeted by several requesters: only one transfer per cycle, so conflicts resolve serially in grant order. The last applied command wins.
- Reset during an active handshake: no command is applied that cycle and all state returns to reset values.
- flags changes only through accepted commands; there is no other write path.

Test Plan:
- Reset, then requester 0 sends S=1,R=0,idx=5 for one cycle -> req_ready=0001 same cycle; next cycle flags=0x20, upd_valid=1, upd_req=0, upd_idx=5.
- All 4 requesters hold valid with set commands to idx 0..3 from reset -> grants in order 0,1,2,3 on four consecutive cycles; flags=0x0F after cycle 4; no requester granted twice.
- Requester 2 sends S=1 on idx 4, then requester 1 sends R=1 on idx 4 on the next grant -> flags[4] goes 1 then 0; final flags[4]=0.
- Requester 3 sends S=1,R=1 idx 2 with flags[2]=1 -> flags[2] stays 1, err=1000, upd_valid pulses. Then err_clr[3] together with a second illegal command from requester 3 -> err[3] stays 1; err_clr alone -> err=0000.
- Requester 1 sends idx=7 with NFLAGS=6 -> no flag changes, err[1]=1. A no-op S=0,R=0 -> accepted, flags unchanged, upd_valid=1.
- Set flags=0xFF via commands, assert reset while requesters 0 and 2 are valid -> the following cycle flags=0, err=0, req_ready=0 during reset; first grant after reset goes to requester 0.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: bank of SR flag bits written by NREQ requesters through a
// round-robin arbiter; illegal commands (S=R=1 or idx out of range) set a sticky error.
module sr_flag_arbiter #(
  parameter int NREQ   = 4,
  parameter int NFLAGS = 8,
  parameter int IDXW   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_s,
  input  logic [NREQ-1:0]      req_r,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NFLAGS-1:0]    flags,
  output logic                 upd_valid,
  output logic [IDXW-1:0]      upd_req,
  output logic [IDXW-1:0]      upd_idx,
  output logic [NREQ-1:0]      err,
  input  logic [NREQ-1:0]      err_clr
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0]     ptr, gid, j, ptr_nxt;
  logic              found, s, r, illegal;
  logic [IDXW-1:0]   idx;
  logic [IDXW-1:0]   idx_a [NREQ];
  logic [NFLAGS-1:0] mask;
  logic [NREQ-1:0]   err_set;
  always_comb begin
    for (int k = 0; k < NREQ; k++) idx_a[k] = req_idx[k*IDXW +: IDXW];
  end
  // first valid requester at or after ptr, wrapping around
  always_comb begin
    found = 1'b0;
    gid   = '0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = PW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[j]) begin
        found = 1'b1;
        gid   = j;
      end
    end
  end
  assign req_ready = (found && !reset) ? NREQ'(1) << gid : '0;
  assign ptr_nxt   = (gid == PW'(NREQ - 1)) ? '0 : gid + PW'(1);
  assign s         = req_s[gid];
  assign r         = req_r[gid];
  assign idx       = idx_a[gid];
  assign illegal   = (s & r) | ({1'b0, idx} >= (IDXW+1)'(NFLAGS));
  assign mask      = NFLAGS'(1) << idx;
  assign err_set   = illegal ? req_ready : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      flags     <= '0;
      err       <= '0;
      upd_valid <= 1'b0;
      upd_req   <= '0;
      upd_idx   <= '0;
    end else begin
      upd_valid <= found;
      err       <= (err & ~err_clr) | err_set;
      if (found) begin
        ptr     <= ptr_nxt;
        upd_req <= IDXW'(gid);
        upd_idx <= idx;
        if (!illegal && (s != r)) flags <= s ? (flags | mask) : (flags & ~mask);
      end
    end
  end
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: table-driven directed vectors for sr_flag_arbiter (NREQ=4, NFLAGS=6).
module tb_sr_flag_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid, req_ready, req_s, req_r, err, err_clr;
  logic [11:0] req_idx;
  logic [5:0]  flags;
  logic        upd_valid;
  logic [2:0]  upd_req, upd_idx;
  int          nvec = 0;
  int          nbad = 0;

  sr_flag_arbiter #(.NREQ(4), .NFLAGS(6), .IDXW(3)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_s(req_s), .req_r(req_r), .req_idx(req_idx), .flags(flags),
    .upd_valid(upd_valid), .upd_req(upd_req), .upd_idx(upd_idx),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v, s, r;
    logic [11:0] idx;
    logic [3:0]  clr;
    logic        rst;
    logic [3:0]  rdy;
    logic [5:0]  fl;
    logic        uv;
    logic [2:0]  ureq, uidx;
    logic [3:0]  er;
  } vec_t;

  localparam int NV = 30;
  vec_t tab [NV];

  function automatic logic [11:0] ix(input logic [2:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [3:0] v, s, r,
                              input logic [11:0] idx, input logic [3:0] clr,
                              input logic [3:0] rdy, input logic [5:0] fl, input logic uv,
                              input logic [2:0] ureq, uidx, input logic [3:0] er);
    vec_t t;
    t.rst = rst; t.v = v; t.s = s; t.r = r; t.idx = idx; t.clr = clr;
    t.rdy = rdy; t.fl = fl; t.uv = uv; t.ureq = ureq; t.uidx = uidx; t.er = er;
    return t;
  endfunction

  task automatic chk(input int n, input string name, input logic [11:0] act, exp);
    if (act !== exp) begin
      nbad++;
      $display("FAIL row %0d %s: got %h want %h", n, name, act, exp);
    end
  endtask

  initial begin
    // rst v s r idx clr | rdy flags uv ureq uidx err (registered fields reflect the previous edge)
    tab[0]  = mk(1, 4'b1111, 4'b1111, 0, ix(0,0,0,0), 0, 4'b0000, 6'h00, 0, 0, 0, 4'b0000);
    tab[1]  = mk(0, 4'b0001, 4'b0001, 0, ix(5,0,0,0), 0, 4'b0001, 6'h00, 0, 0, 0, 4'b0000);
    tab[2]  = mk(0, 4'b0000, 0,       0, ix(0,0,0,0), 0, 4'b0000, 6'h20, 1, 0, 5, 4'b0000);
    tab[3]  = mk(1, 4'b0000, 0,       0, ix(0,0,0,0), 0, 4'b0000, 6'h20, 0, 0, 5, 4'b0000);
    tab[4]  = mk(0, 4'b1111, 4'b1111, 0, ix(0,1,2,3), 0, 4'b0001, 6'h00, 0, 0, 0, 4'b0000);
    tab[5]  = mk(0, 4'b1110, 4'b1111, 0, ix(0,1,2,3), 0, 4'b0010, 6'h01, 1, 0, 0, 4'b0000);
    tab[6]  = mk(0, 4'b1100, 4'b1111, 0, ix(0,1,2,3), 0, 4'b0100, 6'h03, 1, 1, 1, 4'b0000);
    tab[7]  = mk(0, 4'b1000, 4'b1111, 0, ix(0,1,2,3), 0, 4'b1000, 6'h07, 1, 2, 2, 4'b0000);
    tab[8]  = mk(0, 4'b0000, 0,       0, ix(0,0,0,0), 0, 4'b0000, 6'h0F, 1, 3, 3, 4'b0000);
    tab[9]  = mk(0, 4'b0100, 4'b0100, 0,       ix(0,0,4,0), 0, 4'b0100, 6'h0F, 0, 3, 3, 4'b0000);
    tab[10] = mk(0, 4'b0010, 0,       4'b0010, ix(0,4,0,0), 0, 4'b0010, 6'h1F, 1, 2, 4, 4'b0000);
    tab[11] = mk(0, 4'b0000, 0,       0,       ix(0,0,0,0), 0, 4'b0000, 6'h0F, 1, 1, 4, 4'b0000);
    tab[12] = mk(0, 4'b1000, 4'b1000, 4'b1000, ix(0,0,0,2), 0,       4'b1000, 6'h0F, 0, 1, 4, 4'b0000);
    tab[13] = mk(0, 4'b1000, 4'b1000, 4'b1000, ix(0,0,0,2), 4'b1000, 4'b1000, 6'h0F, 1, 3, 2, 4'b1000);
    tab[14] = mk(0, 4'b0000, 0,       0,       ix(0,0,0,0), 4'b1000, 4'b0000, 6'h0F, 1, 3, 2, 4'b1000);
    tab[15] = mk(0, 4'b0000, 0,       0,       ix(0,0,0,0), 0,       4'b0000, 6'h0F, 0, 3, 2, 4'b0000);
    tab[16] = mk(0, 4'b0010, 4'b0010, 0, ix(0,7,0,0), 0,       4'b0010, 6'h0F, 0, 3, 2, 4'b0000);
    tab[17] = mk(0, 4'b0001, 0,       0, ix(1,0,0,0), 0,       4'b0001, 6'h0F, 1, 1, 7, 4'b0010);
    tab[18] = mk(0, 4'b0000, 0,       0, ix(0,0,0,0), 4'b0010, 4'b0000, 6'h0F, 1, 0, 1, 4'b0010);
    tab[19] = mk(0, 4'b0001, 4'b0001, 0, ix(6,0,0,0), 0,       4'b0001, 6'h0F, 0, 0, 1, 4'b0000);
    tab[20] = mk(0, 4'b0000, 0,       0, ix(0,0,0,0), 4'b0001, 4'b0000, 6'h0F, 1, 0, 6, 4'b0001);
    tab[21] = mk(0, 4'b0001, 4'b0001, 0, ix(4,0,0,0), 0,       4'b0001, 6'h0F, 0, 0, 6, 4'b0000);
    tab[22] = mk(0, 4'b0010, 4'b0010, 0, ix(0,5,0,0), 0,       4'b0010, 6'h1F, 1, 0, 4, 4'b0000);
    tab[23] = mk(1, 4'b0101, 0, 4'b0101, ix(0,0,1,0), 0,       4'b0000, 6'h3F, 1, 1, 5, 4'b0000);
    tab[24] = mk(0, 4'b0101, 0, 4'b0101, ix(0,0,1,0), 0,       4'b0001, 6'h00, 0, 0, 0, 4'b0000);
    tab[25] = mk(0, 4'b0100, 0, 4'b0100, ix(0,0,1,0), 0,       4'b0100, 6'h00, 1, 0, 0, 4'b0000);
    tab[26] = mk(0, 4'b0000, 0, 0,       ix(0,0,0,0), 0,       4'b0000, 6'h00, 1, 2, 1, 4'b0000);
    tab[27] = mk(0, 4'b0011, 4'b0011, 0, ix(0,1,0,0), 0,       4'b0001, 6'h00, 0, 2, 1, 4'b0000);
    tab[28] = mk(0, 4'b0000, 0, 0,       ix(0,0,0,0), 0,       4'b0000, 6'h01, 1, 0, 0, 4'b0000);
    tab[29] = mk(0, 4'b0000, 0, 0,       ix(0,0,0,0), 0,       4'b0000, 6'h01, 0, 0, 0, 4'b0000);

    reset = 1'b1; req_valid = '0; req_s = '0; req_r = '0; req_idx = '0; err_clr = '0;
    @(posedge clk); #1;
    for (int n = 0; n < NV; n++) begin
      reset = tab[n].rst; req_valid = tab[n].v; req_s = tab[n].s; req_r = tab[n].r;
      req_idx = tab[n].idx; err_clr = tab[n].clr;
      @(negedge clk);
      nvec++;
      chk(n, "req_ready", 12'(req_ready), 12'(tab[n].rdy));
      chk(n, "flags",     12'(flags),     12'(tab[n].fl));
      chk(n, "upd_valid", 12'(upd_valid), 12'(tab[n].uv));
      chk(n, "upd_req",   12'(upd_req),   12'(tab[n].ureq));
      chk(n, "upd_idx",   12'(upd_idx),   12'(tab[n].uidx));
      chk(n, "err",       12'(err),       12'(tab[n].er));
      @(posedge clk); #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
